prbs_9: RTL and testbench



---
 rtl/prbs_9_if.sv | 15 +
 rtl/prbs_9.sv | 41 ++++
 tb/tb_prbs_9.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/prbs_9_if.sv
// prbs_9_if: generator control/data bundle; master drives Enable (and ErrInject), slave returns PRBS_Pattern
// Signals: Enable advance request, PRBS_Pattern registered byte (bit 0 earliest),
//          ErrInject single-bit error request (present only with PRBS9_ERR_INJ_EN)
interface prbs_9_if;
    logic       Enable;
    logic [7:0] PRBS_Pattern;
`ifdef PRBS9_ERR_INJ_EN
    logic       ErrInject;
    modport master(output Enable, output ErrInject, input PRBS_Pattern);
    modport slave(input Enable, input ErrInject, output PRBS_Pattern);
`else
    modport master(output Enable, input PRBS_Pattern);
    modport slave(input Enable, output PRBS_Pattern);
`endif
endinterface

// File: rtl/prbs_9.sv
// prbs_9: byte-parallel PRBS-9 (x^9 + x^5 + 1) generator, 8 sequence bits per enabled clock, bit 0 first
// Ports: Clk clock; TxRst asynchronous active-low reset; bus (prbs_9_if.slave):
//        Enable advances the generator, PRBS_Pattern is the registered byte,
//        ErrInject (only when PRBS9_ERR_INJ_EN is defined) flips bit 0 of the byte produced this cycle.
module prbs_9 #(
    parameter logic [8:0] SEED   = 9'h1FF,
    parameter bit         INVERT = 1'b0
) (
    input logic     Clk,
    input logic     TxRst,
    prbs_9_if.slave bus
);
    // an all-zero seed would lock the LFSR, so it is replaced by all-ones
    localparam logic [8:0] SEED_EFF = (SEED == 9'h000) ? 9'h1FF : SEED;
    logic [8:0] state_q, state_d, s;
    logic [7:0] pattern_q, pattern_d, p;
    always_comb begin
        s = state_q;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p[k] = s[8] ^ INVERT;
            s    = {s[7:0], s[8] ^ s[4]};
        end
`ifdef PRBS9_ERR_INJ_EN
        p[0] = p[0] ^ bus.ErrInject;
`endif
        // lock-up recovery takes priority over Enable
        state_d   = (state_q == 9'h000) ? SEED_EFF : bus.Enable ? s : state_q;
        pattern_d = bus.Enable ? p : pattern_q;
    end
    always_ff @(posedge Clk or negedge TxRst) begin
        if (!TxRst) begin
            state_q   <= SEED_EFF;
            pattern_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
        end
    end
    assign bus.PRBS_Pattern = pattern_q;
endmodule

// File: tb/tb_prbs_9.sv
// tb_prbs_9: randomized scoreboard bench for prbs_9 against a recurrence-based sequence model
module tb_prbs_9;
    logic Clk = 1'b0;
    logic TxRst = 1'b0;
    prbs_9_if bus();
    prbs_9 dut (.Clk(Clk), .TxRst(TxRst), .bus(bus));
    always #5 Clk = ~Clk;

    int  cmp_cnt = 0;
    int  err_cnt = 0;
    bit  a [0:510];
    int  n = 0;
    logic [7:0] sb [$];
    logic [7:0] hold = 8'h00;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input int idx);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = a[(8 * idx + k) % 511];
        return b;
    endfunction

    task automatic step(input bit en, input bit ei);
        logic [7:0] e;
        bit x;
        @(negedge Clk);
        bus.Enable = en;
`ifdef PRBS9_ERR_INJ_EN
        bus.ErrInject = ei;
        x = ei;
`else
        x = 1'b0;
`endif
        if (en) begin
            e = model_byte(n);
            e[0] = e[0] ^ x;
            sb.push_back(e);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        TxRst = 1'b0;
        bus.Enable = 1'b0;
        sb.delete();
        n = 0;
        repeat (5) @(negedge Clk);
        TxRst = 1'b1;
    endtask

    task automatic check_after_edge(input string nm, input logic [7:0] exp);
        @(posedge Clk);
        #2;
        chk(nm, bus.PRBS_Pattern, exp);
    endtask

    // monitor: pops one expected byte per enabled edge, otherwise the output must hold
    initial begin
        bit en;
        forever begin
            @(posedge Clk);
            en = bus.Enable && TxRst;
            #1;
            if (!TxRst) begin
                hold = 8'h00;
                chk("reset_out", bus.PRBS_Pattern, 8'h00);
            end else begin
                if (en) begin
                    if (sb.size() == 0) begin
                        err_cnt++;
                        $display("FAIL sb_underflow: got no expected byte, required one at %0t", $time);
                    end else hold = sb.pop_front();
                end
                chk(en ? "stream" : "hold", bus.PRBS_Pattern, hold);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] seed = 9'h1FF;
        for (int i = 0; i < 9; i++) a[i] = seed[8 - i];
        for (int i = 9; i < 511; i++) a[i] = a[i - 9] ^ a[i - 5];
        bus.Enable = 1'b0;
`ifdef PRBS9_ERR_INJ_EN
        bus.ErrInject = 1'b0;
`endif
        // reset held, then released with Enable low: output stays zero
        repeat (5) @(negedge Clk);
        TxRst = 1'b1;
        repeat (5) step(1'b0, 1'b0);
        // first bytes, then a 5-cycle Enable gap
        step(1'b1, 1'b0);
        check_after_edge("byte1", 8'hFF);
        step(1'b1, 1'b0);
        check_after_edge("byte2", 8'hC1);
        repeat (5) begin
            step(1'b0, 1'b0);
            check_after_edge("gap_hold", 8'hC1);
        end
        step(1'b1, 1'b0);
        check_after_edge("byte3", 8'hFB);
        // long continuous run covering the 511-byte wrap
        do_reset();
        for (int i = 0; i < 550; i++) begin
            step(1'b1, 1'b0);
            if (i >= 511 && i <= 513)
                check_after_edge("wrap", i == 511 ? 8'hFF : i == 512 ? 8'hC1 : 8'hFB);
        end
        // random Enable, including every-other-cycle toggling
        for (int i = 0; i < 300; i++) step(1'(($urandom % 3) != 0), 1'b0);
        for (int i = 0; i < 40; i++) step(1'(i % 2), 1'b0);
        // asynchronous reset between edges
        @(posedge Clk);
        #3;
        TxRst = 1'b0;
        #1;
        chk("async_reset", bus.PRBS_Pattern, 8'h00);
        sb.delete();
        n = 0;
        bus.Enable = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        TxRst = 1'b1;
        step(1'b1, 1'b0);
        check_after_edge("after_reset", 8'hFF);
        for (int i = 0; i < 100; i++) step(1'(($urandom % 2) != 0), 1'b0);
`ifdef PRBS9_ERR_INJ_EN
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_after_edge("err_inj", 8'hC0);
        step(1'b1, 1'b0);
        check_after_edge("after_err", 8'hFB);
        step(1'b0, 1'b1);
        check_after_edge("err_ignored", 8'hFB);
        for (int i = 0; i < 100; i++) step(1'(($urandom % 2) != 0), 1'(($urandom % 8) == 0));
`endif
        step(1'b0, 1'b0);
        repeat (3) @(negedge Clk);
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
